// File: rtl/object_renderer_if.sv
// object_renderer_if -- raster, descriptor and pixel-output bundle for object_renderer.
//
// Groups every object_renderer signal except clk/rst.
//   master : raster timing generator / object module side (drives scan + descriptor)
//   slave  : object_renderer side (consumes scan + descriptor, drives pixel results)
// Signals:
//   hcount, vcount      raster column/row (CW bits)
//   video_on            visible-area qualifier
//   frame_start         one-cycle pulse on the first clock of a frame
//   obj_*               object descriptor (position, size, offsets, color)
//   bg_opaque           background layer non-empty, aligned with hcount/vcount
//   pix_color, pix_hit  composited pixel and object-hit flag (2-clock latency)
//   collision           object overlapped opaque background in the previous frame
//   pix_count           object pixels drawn in the previous frame
interface object_renderer_if #(
    parameter int unsigned CW = 11
);
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          video_on;
    logic          frame_start;
    logic [31:0]   obj_vStartPos;
    logic [31:0]   obj_hStartPos;
    logic [31:0]   obj_width;
    logic [31:0]   obj_height;
    logic [31:0]   obj_vOffset;
    logic [31:0]   obj_hOffset;
    logic [3:0]    obj_color;
    logic          bg_opaque;
    logic [3:0]    pix_color;
    logic          pix_hit;
    logic          collision;
    logic [31:0]   pix_count;

    modport master (
        output hcount, vcount, video_on, frame_start,
        output obj_vStartPos, obj_hStartPos, obj_width, obj_height,
        output obj_vOffset, obj_hOffset, obj_color, bg_opaque,
        input  pix_color, pix_hit, collision, pix_count
    );

    modport slave (
        input  hcount, vcount, video_on, frame_start,
        input  obj_vStartPos, obj_hStartPos, obj_width, obj_height,
        input  obj_vOffset, obj_hOffset, obj_color, bg_opaque,
        output pix_color, pix_hit, collision, pix_count
    );
endinterface

// File: rtl/object_renderer.sv
// object_renderer -- draws one rectangular object over the raster and reports per-frame stats.
//
// Ports:
//   clk  pixel clock
//   rst  asynchronous active-low reset
//   bus  object_renderer_if.slave (scan inputs, object descriptor, pixel results)
// Parameters:
//   BG_COLOR  color shown where the object is not drawn
//   CW        width of hcount/vcount (at most 32)
// Build option:
//   OBJ_RENDER_BORDER_EN  when defined, the outermost rows/columns of the object are drawn
//                         with the inverted object color; hit/count/collision are unaffected.
//
// Pipeline: stage 1 registers the hit test, stage 2 registers the composited pixel, so scan
// inputs reach pix_color/pix_hit two clocks later. The descriptor is shadowed on frame_start.
module object_renderer #(
    parameter logic [3:0]  BG_COLOR = 4'h0,
    parameter int unsigned CW       = 11
) (
    input logic              clk,
    input logic              rst,
    object_renderer_if.slave bus
);

    typedef enum logic [0:0] {StWaitFrame, StActive} state_e;

    state_e state_q, state_d;

    // Shadowed descriptor
    logic [31:0] top_q, left_q, width_q, height_q;
    logic [3:0]  color_q;

    // Stage 1
    logic        s1_hit_q, s1_bg_q;
    logic [3:0]  s1_color_q;
    logic        s1_hit_d;
    logic [3:0]  s1_color_d;

    // Stage 2 / outputs
    logic        pix_hit_q, s2_bg_q;
    logic [3:0]  pix_color_q;

    // Frame statistics
    logic [31:0] cnt_q, cnt_d;
    logic        sticky_q, sticky_d;
    logic [31:0] pix_count_q;
    logic        collision_q;

    // Hit test with 33-bit end bounds so regions past 2^32 clip instead of wrapping
    logic [32:0] h_ext, v_ext;
    logic [32:0] left_end, top_end;
    logic        in_h, in_v;

    assign h_ext    = 33'(bus.hcount);
    assign v_ext    = 33'(bus.vcount);
    assign left_end = {1'b0, left_q} + {1'b0, width_q};
    assign top_end  = {1'b0, top_q} + {1'b0, height_q};
    assign in_h     = (h_ext >= {1'b0, left_q}) && (h_ext < left_end);
    assign in_v     = (v_ext >= {1'b0, top_q}) && (v_ext < top_end);

    always_comb begin
        state_d = state_q;
        if (state_q == StWaitFrame && bus.frame_start) begin
            state_d = StActive;
        end
    end

    always_comb begin
        s1_hit_d   = (state_q == StActive) && bus.video_on && in_h && in_v;
        s1_color_d = color_q;
`ifdef OBJ_RENDER_BORDER_EN
        if ((h_ext == {1'b0, left_q}) || (h_ext + 33'd1 == left_end) ||
            (v_ext == {1'b0, top_q})  || (v_ext + 33'd1 == top_end)) begin
            s1_color_d = ~color_q;
        end
`endif
    end

    // Statistics: the hit visible in the frame_start cycle belongs to the new frame
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (bus.frame_start) begin
            cnt_d    = {31'b0, pix_hit_q};
            sticky_d = pix_hit_q && s2_bg_q;
        end else begin
            if (pix_hit_q && cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
            if (pix_hit_q && s2_bg_q) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StWaitFrame;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q    <= '0;
            left_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            color_q  <= '0;
        end else if (bus.frame_start) begin
            top_q    <= bus.obj_vStartPos + bus.obj_vOffset;
            left_q   <= bus.obj_hStartPos + bus.obj_hOffset;
            width_q  <= bus.obj_width;
            height_q <= bus.obj_height;
            color_q  <= bus.obj_color;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hit_q    <= 1'b0;
            s1_bg_q     <= 1'b0;
            s1_color_q  <= '0;
            pix_hit_q   <= 1'b0;
            s2_bg_q     <= 1'b0;
            pix_color_q <= BG_COLOR;
        end else begin
            s1_hit_q    <= s1_hit_d;
            s1_bg_q     <= bus.bg_opaque;
            s1_color_q  <= s1_color_d;
            pix_hit_q   <= s1_hit_q;
            s2_bg_q     <= s1_bg_q;
            pix_color_q <= s1_hit_q ? s1_color_q : BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            pix_count_q <= '0;
            collision_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            if (bus.frame_start) begin
                pix_count_q <= cnt_q;
                collision_q <= sticky_q;
            end
        end
    end

    assign bus.pix_color = pix_color_q;
    assign bus.pix_hit   = pix_hit_q;
    assign bus.pix_count = pix_count_q;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_object_renderer.sv
// Testbench for object_renderer: directed scenarios plus randomized frames, all outputs
// compared every cycle against a rectangle-membership model with a two-deep output delay.
module tb_object_renderer;

    localparam int unsigned CW = 11;
    localparam logic [3:0]  BG = 4'h5;
`ifdef OBJ_RENDER_BORDER_EN
    localparam logic [3:0]  CornerColor = 4'h3;
`else
    localparam logic [3:0]  CornerColor = 4'hC;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    object_renderer_if #(.CW(CW)) bus ();

    object_renderer #(
        .BG_COLOR(BG),
        .CW      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        bit         hit;
        bit         bg;
        logic [3:0] color;
        int         h;
        int         v;
    } pix_t;

    // Model state
    bit              m_active;
    logic [31:0]     m_top, m_left, m_w, m_h;
    logic [3:0]      m_col;
    pix_t            m_vis, m_p1;
    longint unsigned m_tally;
    logic [31:0]     m_rep_count;
    bit              m_rep_coll;
    bit              m_sticky;

    int errors = 0;
    int checks = 0;
    int pin_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_top       = '0;
        m_left      = '0;
        m_w         = '0;
        m_h         = '0;
        m_col       = '0;
        m_vis       = '{hit: 0, bg: 0, color: BG, h: -1, v: -1};
        m_p1        = m_vis;
        m_tally     = 0;
        m_rep_count = '0;
        m_rep_coll  = 0;
        m_sticky    = 0;
    endtask

    // Is the current scan position inside the latched rectangle (no wrap, exact bounds)?
    function automatic pix_t predict();
        pix_t p;
        longint unsigned h, v, l, t, w, ht;
        h  = longint'(bus.hcount);
        v  = longint'(bus.vcount);
        l  = longint'(m_left);
        t  = longint'(m_top);
        w  = longint'(m_w);
        ht = longint'(m_h);
        p.h   = int'(h);
        p.v   = int'(v);
        p.bg  = bus.bg_opaque;
        p.hit = m_active && bus.video_on && h >= l && h < l + w && v >= t && v < t + ht;
        p.color = BG;
        if (p.hit) begin
            p.color = m_col;
`ifdef OBJ_RENDER_BORDER_EN
            if (h == l || h == l + w - 1 || v == t || v == t + ht - 1) p.color = ~m_col;
`endif
        end
        return p;
    endfunction

    // One clock: model advance with the inputs currently applied, then compare after the edge.
    task automatic step();
        pix_t nxt;
        nxt = predict();
        if (bus.frame_start) begin
            m_rep_count = m_tally[31:0];
            m_rep_coll  = m_sticky;
            m_tally     = m_vis.hit ? 1 : 0;
            m_sticky    = m_vis.hit && m_vis.bg;
            m_top       = bus.obj_vStartPos + bus.obj_vOffset;
            m_left      = bus.obj_hStartPos + bus.obj_hOffset;
            m_w         = bus.obj_width;
            m_h         = bus.obj_height;
            m_col       = bus.obj_color;
            m_active    = 1;
        end else begin
            if (m_vis.hit && m_tally < 64'hFFFF_FFFF) m_tally++;
            if (m_vis.hit && m_vis.bg) m_sticky = 1;
        end
        m_vis = m_p1;
        m_p1  = nxt;
        @(posedge clk);
        #1;
        check("pix_hit", {31'b0, bus.pix_hit}, {31'b0, m_vis.hit});
        check("pix_color", {28'b0, bus.pix_color}, {28'b0, m_vis.color});
        check("pix_count", bus.pix_count, m_rep_count);
        check("collision", {31'b0, bus.collision}, {31'b0, m_rep_coll});
        if (pin_mode == 1 && m_vis.h == 308 && m_vis.v == 384) begin
            check("pin_corner_hit", {31'b0, bus.pix_hit}, 32'd1);
            check("pin_corner_color", {28'b0, bus.pix_color}, {28'b0, CornerColor});
        end
        if (pin_mode == 1 && m_vis.h == 310 && m_vis.v == 386) begin
            check("pin_interior_color", {28'b0, bus.pix_color}, 32'hC);
        end
        if (pin_mode == 1 && m_vis.h == 320 && m_vis.v == 388) begin
            check("pin_right_edge_miss", {31'b0, bus.pix_hit}, 32'd0);
        end
        if (pin_mode == 2 && m_vis.h == 308 && m_vis.v == 390) begin
            check("pin_moved_old_col", {31'b0, bus.pix_hit}, 32'd0);
        end
        if (pin_mode == 2 && m_vis.h == 323 && m_vis.v == 390) begin
            check("pin_moved_new_col", {31'b0, bus.pix_hit}, 32'd1);
        end
    endtask

    task automatic idle(input int n);
        bus.video_on    = 0;
        bus.bg_opaque   = 0;
        bus.frame_start = 0;
        bus.hcount      = '0;
        bus.vcount      = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame_pulse();
        bus.video_on    = 0;
        bus.bg_opaque   = 0;
        bus.hcount      = '0;
        bus.vcount      = '0;
        bus.frame_start = 1;
        step();
        bus.frame_start = 0;
    endtask

    task automatic scan(input int h0, input int h1, input int v0, input int v1,
                        input int bgh, input int bgv);
        bus.frame_start = 0;
        for (int v = v0; v <= v1; v++) begin
            for (int h = h0; h <= h1; h++) begin
                bus.hcount    = CW'(h);
                bus.vcount    = CW'(v);
                bus.video_on  = 1;
                bus.bg_opaque = (h == bgh && v == bgv);
                step();
            end
        end
    endtask

    task automatic set_desc(input logic [31:0] vs, input logic [31:0] hs, input logic [31:0] w,
                            input logic [31:0] ht, input logic [31:0] vo, input logic [31:0] ho,
                            input logic [3:0] c);
        bus.obj_vStartPos = vs;
        bus.obj_hStartPos = hs;
        bus.obj_width     = w;
        bus.obj_height    = ht;
        bus.obj_vOffset   = vo;
        bus.obj_hOffset   = ho;
        bus.obj_color     = c;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hit"}, {31'b0, bus.pix_hit}, 32'd0);
        check({tag, "_color"}, {28'b0, bus.pix_color}, {28'b0, BG});
        check({tag, "_count"}, bus.pix_count, 32'd0);
        check({tag, "_coll"}, {31'b0, bus.collision}, 32'd0);
    endtask

    initial begin
        bus.hcount      = '0;
        bus.vcount      = '0;
        bus.video_on    = 0;
        bus.frame_start = 0;
        bus.bg_opaque   = 0;
        set_desc(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'h0);
        model_reset();

        // Reset
        #2 rst = 0;
        #1 check_reset_outputs("reset");
        @(posedge clk);
        #1 check_reset_outputs("reset_held");
        rst = 1;
        idle(3);

        // Waiting for the first frame: nothing drawn even inside the region
        set_desc(32'd384, 32'd308, 32'd12, 32'd12, 32'd0, 32'd0, 4'hC);
        scan(306, 312, 384, 385, -1, -1);

        // Frame A: basic draw, collision at (310,390), offset change mid-frame
        frame_pulse();
        check("first_frame_count", bus.pix_count, 32'd0);
        pin_mode = 1;
        scan(300, 325, 380, 389, -1, -1);
        bus.obj_hOffset = 32'd4;
        scan(300, 325, 390, 400, 310, 390);
        pin_mode = 0;
        idle(3);
        frame_pulse();
        check("frameA_count", bus.pix_count, 32'd144);
        check("frameA_collision", {31'b0, bus.collision}, 32'd1);

        // Frame B: moved by hOffset=4, no opaque background
        pin_mode = 2;
        scan(300, 330, 380, 400, -1, -1);
        pin_mode = 0;
        idle(3);
        frame_pulse();
        check("frameB_count", bus.pix_count, 32'd144);
        check("frameB_collision", {31'b0, bus.collision}, 32'd0);

        // Back-to-back frame_start: zero-length frame
        frame_pulse();
        check("zero_frame_count", bus.pix_count, 32'd0);
        check("zero_frame_coll", {31'b0, bus.collision}, 32'd0);

        // Region running past 2^32 is clipped
        set_desc(32'd384, 32'hFFFF_FFFC, 32'd12, 32'd12, 32'd0, 32'd0, 4'hC);
        frame_pulse();
        scan(0, 15, 384, 386, -1, -1);
        idle(3);
        frame_pulse();
        check("clip_count", bus.pix_count, 32'd0);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            set_desc($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 8), $urandom_range(0, 8),
                     4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                bus.obj_hStartPos = $urandom;
                bus.obj_hOffset   = 32'($urandom_range(0, 40)) - bus.obj_hStartPos;
            end
            if ($urandom_range(0, 3) == 0) bus.obj_hStartPos = 32'hFFFF_FFF8;
            frame_pulse();
            if ($urandom_range(0, 4) == 0) frame_pulse();
            for (int c = 0; c < 150; c++) begin
                bus.hcount      = CW'($urandom_range(0, 50));
                bus.vcount      = CW'($urandom_range(0, 50));
                bus.video_on    = ($urandom_range(0, 9) < 8);
                bus.bg_opaque   = ($urandom_range(0, 9) < 3);
                bus.frame_start = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 49) == 0) bus.obj_hOffset = $urandom_range(0, 20);
                if ($urandom_range(0, 49) == 0) bus.obj_color = 4'($urandom);
                step();
            end
            bus.frame_start = 0;
        end

        // Asynchronous reset in the middle of a drawn row
        set_desc(32'd384, 32'd308, 32'd12, 32'd12, 32'd0, 32'd0, 4'hC);
        frame_pulse();
        scan(300, 325, 388, 389, -1, -1);
        scan(300, 314, 390, 390, -1, -1);
        check("pre_reset_hit", {31'b0, bus.pix_hit}, 32'd1);
        bus.hcount = CW'(315);
        rst = 0;
        #2 check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1 check_reset_outputs("async_reset_held");
        rst = 1;
        scan(300, 325, 390, 392, -1, -1);
        frame_pulse();
        scan(300, 325, 384, 385, -1, -1);
        idle(3);
        frame_pulse();
        check("post_reset_count", bus.pix_count, 32'd24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
